bus_arbiter_rr: RTL and testbench

Round-robin arbiter and slave-select sequencer for the serial data bus. It grants the bus to one of `NUM_MASTERS` requesting masters and checks that the addressed slave's `busy_out` is low. It then shifts a select frame onto the shared arbiter command line, which every slave's `arbiter_cmd_in` samples, and holds `bus_util` and the grant until the master finishes or a watchdog expires. It sits at top level between the master modules and the slave modules, including the memory slaves.

---
 rtl/bus_arbiter_rr.sv | 170 +++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: picks a requesting master, waits for its target slave to be free,
// shifts a select frame onto the arbiter command line, then holds the grant until done or timeout.
module bus_arbiter_rr #(
    parameter int unsigned NUM_MASTERS    = 3,
    parameter int unsigned SLAVE_ID_WIDTH = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_MASTERS-1:0]                 mreq,
    input  logic [NUM_MASTERS*SLAVE_ID_WIDTH-1:0]  slave_id_in,
    input  logic [NUM_MASTERS-1:0]                 mdone,
    input  logic [(2**SLAVE_ID_WIDTH)-1:0]         slave_busy,
    output logic [NUM_MASTERS-1:0]                 grant,
    output logic                                   arbiter_cmd_out,
    output logic                                   bus_util,
    output logic                                   timeout_err
);

    localparam int unsigned IdxW = $clog2(NUM_MASTERS);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned BitW = $clog2(SLAVE_ID_WIDTH + 1);

    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_MASTERS - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(SLAVE_ID_WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StCmd,
        StGrant,
        StRelease
    } state_e;

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]           winner_q, winner_d;
    logic [SLAVE_ID_WIDTH-1:0] id_q, id_d;
    logic [BitW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0]           cyc_cnt_q, cyc_cnt_d;
    logic [NUM_MASTERS-1:0]    grant_q, grant_d;
    logic                      cmd_q, cmd_d;
    logic                      bus_util_q, bus_util_d;
    logic                      timeout_err_q, timeout_err_d;

    logic                      pick_found;
    logic [IdxW-1:0]           pick_idx;
    logic [IdxW-1:0]           scan_idx;
    logic                      owner_done;
    logic [IdxW-1:0]           rr_next;

    // Scan upward from rr_ptr with wrap; first set request wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        scan_idx   = rr_ptr_q;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (!pick_found && mreq[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
            scan_idx = (scan_idx == IdxLast) ? '0 : scan_idx + 1'b1;
        end
    end

    assign owner_done = mdone[winner_q] || !mreq[winner_q];
    assign rr_next    = (winner_q == IdxLast) ? '0 : winner_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        winner_d      = winner_q;
        id_d          = id_q;
        bit_cnt_d     = bit_cnt_q;
        cyc_cnt_d     = cyc_cnt_q;
        grant_d       = grant_q;
        cmd_d         = cmd_q;
        bus_util_d    = bus_util_q;
        timeout_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                grant_d    = '0;
                cmd_d      = 1'b0;
                bus_util_d = 1'b0;
                if (pick_found) begin
                    winner_d = pick_idx;
                    id_d     = slave_id_in[int'(pick_idx)*SLAVE_ID_WIDTH +: SLAVE_ID_WIDTH];
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (!mreq[winner_q]) begin
                    state_d = StIdle;
                end else if (!slave_busy[id_q]) begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                    cmd_d     = 1'b1;
                end
            end
            StCmd: begin
                // id_q doubles as the frame shift register, MSB first.
                if (bit_cnt_q == BitLast) begin
                    state_d    = StGrant;
                    cmd_d      = 1'b0;
                    grant_d    = NUM_MASTERS'(1) << winner_q;
                    bus_util_d = 1'b1;
                    cyc_cnt_d  = '0;
                end else begin
                    cmd_d     = id_q[SLAVE_ID_WIDTH-1];
                    id_d      = id_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StGrant: begin
                if (owner_done || (cyc_cnt_q == CntLast)) begin
                    state_d       = StRelease;
                    grant_d       = '0;
                    bus_util_d    = 1'b0;
                    rr_ptr_d      = rr_next;
                    timeout_err_d = !owner_done;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d    = StIdle;
                grant_d    = '0;
                cmd_d      = 1'b0;
                bus_util_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            winner_q      <= '0;
            id_q          <= '0;
            bit_cnt_q     <= '0;
            cyc_cnt_q     <= '0;
            grant_q       <= '0;
            cmd_q         <= 1'b0;
            bus_util_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            winner_q      <= winner_d;
            id_q          <= id_d;
            bit_cnt_q     <= bit_cnt_d;
            cyc_cnt_q     <= cyc_cnt_d;
            grant_q       <= grant_d;
            cmd_q         <= cmd_d;
            bus_util_q    <= bus_util_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant           = grant_q;
    assign arbiter_cmd_out = cmd_q;
    assign bus_util        = bus_util_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: per-cycle vector tables through a scoreboard queue,
// plus hand-written fairness, timeout and reset sequences.
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mreq;
    logic [5:0] slave_id_in;
    logic [2:0] mdone;
    logic [3:0] slave_busy;
    logic [2:0] grant;
    logic       arbiter_cmd_out;
    logic       bus_util;
    logic       timeout_err;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    typedef struct {
        logic [2:0] mreq;
        logic [5:0] sid;
        logic [3:0] busy;
        logic [2:0] mdone;
        logic [2:0] e_grant;
        logic       e_cmd;
        logic       e_util;
        logic       e_terr;
    } vec_t;

    logic [5:0] sb_q[$];
    vec_t       vq[$];
    vec_t       tbl[8];

    bus_arbiter_rr #(
        .NUM_MASTERS   (3),
        .SLAVE_ID_WIDTH(2),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mreq           (mreq),
        .slave_id_in    (slave_id_in),
        .mdone          (mdone),
        .slave_busy     (slave_busy),
        .grant          (grant),
        .arbiter_cmd_out(arbiter_cmd_out),
        .bus_util       (bus_util),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [2:0] m, input logic [5:0] s, input logic [3:0] b,
                                input logic [2:0] d, input logic [2:0] g, input logic c,
                                input logic u, input logic t);
        vec_t v;
        v.mreq = m; v.sid = s; v.busy = b; v.mdone = d;
        v.e_grant = g; v.e_cmd = c; v.e_util = u; v.e_terr = t;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [31:0] outs();
        return {26'b0, grant, arbiter_cmd_out, bus_util, timeout_err};
    endfunction

    // Drive one vector at a negedge, compare outputs after the following posedge.
    task automatic apply(input vec_t v, input string name);
        logic [5:0] e;
        mreq = v.mreq; slave_id_in = v.sid; slave_busy = v.busy; mdone = v.mdone;
        sb_q.push_back({v.e_grant, v.e_cmd, v.e_util, v.e_terr});
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        chk(name, outs(), {26'b0, e});
    endtask

    task automatic run_queue(input string name);
        while (vq.size() > 0) apply(vq.pop_front(), name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mreq = '0; mdone = '0; slave_busy = '0; slave_id_in = '0;
        rst = 1'b1;
        #1;
        chk("reset_outputs", outs(), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic wait_grant(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Entered at the first negedge with grant high; pulses mdone when the grant has been
    // seen for pulse_at cycles (0 = never).
    task automatic run_grant(input int pulse_at, output int len, output logic terr_rel,
                             output logic terr_after);
        len = 1;
        for (int i = 0; i < 400; i++) begin
            if (len == pulse_at) mdone = grant;
            @(negedge clk);
            mdone = '0;
            if (grant == '0) break;
            len++;
        end
        terr_rel = timeout_err;
        @(negedge clk);
        terr_after = timeout_err;
    endtask

    initial begin
        int         len;
        logic       ok, t_rel, t_aft;
        int         ord_q[$];
        int         e;

        rst = 1'b1; mreq = '0; mdone = '0; slave_busy = '0; slave_id_in = '0;

        // Single request: master 1 -> slave 2, frame 1,1,0 then grant 010.
        tbl[0] = mk(3'b010, 6'b001000, 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(3'b010, 6'b001000, 4'b0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        tbl[2] = mk(3'b010, 6'b001000, 4'b0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        tbl[3] = mk(3'b010, 6'b001000, 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        tbl[4] = mk(3'b010, 6'b001000, 4'b0000, 3'b000, 3'b010, 1'b0, 1'b1, 1'b0);
        tbl[5] = mk(3'b010, 6'b001000, 4'b0000, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
        tbl[6] = mk(3'b000, 6'b001000, 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        tbl[7] = mk(3'b000, 6'b001000, 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("single_row%0d", i));

        // Busy slave: master 0 -> slave 3 held busy for 10 cycles, then frame 1,1,1.
        do_reset();
        for (int i = 0; i < 10; i++)
            vq.push_back(mk(3'b001, 6'b000011, 4'b1000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(3'b001, 6'b000011, 4'b0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(3'b001, 6'b000011, 4'b0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(3'b001, 6'b000011, 4'b0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(3'b001, 6'b000011, 4'b1000, 3'b000, 3'b001, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk(3'b001, 6'b000011, 4'b1000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(3'b000, 6'b000011, 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
        run_queue("busy_wait");

        // Request dropped while waiting: back to IDLE, rr_ptr stays 0 so master 0 wins next.
        do_reset();
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(3'b001, 6'b000011, 4'b1000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(3'b000, 6'b000011, 4'b1000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(3'b011, 6'b000111, 4'b0000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(3'b011, 6'b000111, 4'b0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(3'b011, 6'b000111, 4'b0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(3'b011, 6'b000111, 4'b0000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(3'b011, 6'b000111, 4'b0000, 3'b000, 3'b001, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk(3'b000, 6'b000111, 4'b0000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0));
        run_queue("busy_drop");

        // Fairness: all masters request continuously, mdone 5 cycles into each grant.
        do_reset();
        ord_q = '{0, 1, 2, 0, 1, 2};
        slave_id_in = 6'b100100;
        mreq = 3'b111;
        for (int n = 0; n < 6; n++) begin
            wait_grant(ok);
            chk($sformatf("fair_wait%0d", n), {31'b0, ok}, 32'd1);
            if (!ok) break;
            e = ord_q.pop_front();
            chk($sformatf("fair_grant%0d", n), {29'b0, grant}, 32'(1) << e);
            run_grant(5, len, t_rel, t_aft);
            chk($sformatf("fair_len%0d", n), len, 32'd5);
        end
        mreq = '0;

        // Timeout: master 2 never finishes.
        do_reset();
        slave_id_in = 6'b000000;
        mreq = 3'b100;
        wait_grant(ok);
        chk("to_grant", {29'b0, grant}, 32'b100);
        run_grant(0, len, t_rel, t_aft);
        chk("to_len", len, 32'd255);
        chk("to_err_pulse", {31'b0, t_rel}, 32'd1);
        chk("to_err_clear", {31'b0, t_aft}, 32'd0);
        mreq = 3'b101;
        wait_grant(ok);
        chk("to_next_m0", {29'b0, grant}, 32'b001);

        // mdone on the final grant cycle: normal release.
        do_reset();
        mreq = 3'b100;
        wait_grant(ok);
        chk("to2_grant", {29'b0, grant}, 32'b100);
        run_grant(255, len, t_rel, t_aft);
        chk("to2_len", len, 32'd255);
        chk("to2_no_err", {31'b0, t_rel}, 32'd0);

        // Reset during the ID bits of the frame.
        do_reset();
        slave_id_in = 6'b001000;
        mreq = 3'b010;
        repeat (3) @(negedge clk);
        chk("pre_rst_cmd", {31'b0, arbiter_cmd_out}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_cmd_async", outs(), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mreq = '0;

        // Master 0 completes (rr_ptr -> 1), then reset in the middle of master 1's grant.
        mreq = 3'b001;
        @(negedge clk);
        wait_grant(ok);
        chk("rst_m0_grant", {29'b0, grant}, 32'b001);
        run_grant(2, len, t_rel, t_aft);
        mreq = 3'b010;
        wait_grant(ok);
        chk("rst_m1_grant", {29'b0, grant}, 32'b010);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_grant_async", outs(), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mreq = 3'b011;
        wait_grant(ok);
        chk("rst_restart_m0", {29'b0, grant}, 32'b001);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
